// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared types and defaults for the RV32M multiply/divide unit.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF   = 3;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one combinational shift-add (mul) or restoring shift-subtract
//               (div) iteration on the 2*DATA_WIDTH accumulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_div,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  output logic [2*DATA_WIDTH-1:0] acc_out
);

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_upper;
  logic [DATA_WIDTH-1:0] div_diff;
  logic                  div_ge;

  always_comb begin
    // Mul: multiplier sits in the low half and is consumed LSB first.
    mul_sum   = {1'b0, acc_in[2*DATA_WIDTH-1:DATA_WIDTH]}
              + (acc_in[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}});
    // Div: partial remainder shifted left by one, next dividend bit appended.
    div_upper = acc_in[2*DATA_WIDTH-1:DATA_WIDTH-1];
    div_ge    = (div_upper >= {1'b0, operand});
    div_diff  = div_upper[DATA_WIDTH-1:0] - operand;
    if (is_div) begin
      if (div_ge)
        acc_out = {div_diff, acc_in[DATA_WIDTH-2:0], 1'b1};
      else
        acc_out = {div_upper[DATA_WIDTH-1:0], acc_in[DATA_WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {mul_sum, acc_in[DATA_WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit (IDLE/CALC/FIX/DONE).
//               Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [OP_WIDTH-1:0]   MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  muldiv_state_e state, state_next;
  muldiv_op_e    op_in, op_q;

  logic [5:0]              cnt;
  logic [2*DATA_WIDTH-1:0] acc, acc_step, prod;
  logic [DATA_WIDTH-1:0]   operand_b, src_a_q, mag_a, mag_b;
  logic [DATA_WIDTH-1:0]   quo, rem, fix_result;
  logic                    neg_q, neg_r, dz_q, ovf_q;
  logic                    accept, a_neg, b_neg, is_div_in;
  logic                    div_zero_in, overflow_in, skip_in;

  assign op_in = muldiv_op_e'(MulDivOp[2:0]);

  always_comb begin
    accept      = Start && !Flush && (state == ST_IDLE || state == ST_DONE);
    is_div_in   = op_in[2];
    a_neg       = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[DATA_WIDTH-1];
    b_neg       = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && SrcB[DATA_WIDTH-1];
    mag_a       = a_neg ? -SrcA : SrcA;
    mag_b       = b_neg ? -SrcB : SrcB;
    div_zero_in = is_div_in && (SrcB == '0);
    overflow_in = (op_in == OP_DIV || op_in == OP_REM)
               && (SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (SrcB == '1);
`ifdef MULDIV_FAST_MUL_EN
    skip_in     = div_zero_in || overflow_in || !is_div_in;
`else
    skip_in     = div_zero_in || overflow_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = skip_in ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == 6'(DATA_WIDTH-1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = accept ? (skip_in ? ST_FIX : ST_CALC) : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (Flush) state_next = ST_IDLE;
  end

  always_comb begin
    Busy = (state == ST_CALC) || (state == ST_FIX);
    Done = (state == ST_DONE);
  end

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div  (op_q[2]),
    .operand (operand_b),
    .acc_in  (acc),
    .acc_out (acc_step)
  );

  // Magnitude result is re-signed here; special div cases bypass the datapath.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
    rem  = neg_r ? -acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[2*DATA_WIDTH-1:DATA_WIDTH];
    case (op_q)
      OP_MUL:                       fix_result = prod[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              fix_result = dz_q ? '1 : (ovf_q ? src_a_q : quo);
      default:                      fix_result = dz_q ? src_a_q : (ovf_q ? '0 : rem);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      op_q      <= OP_MUL;
      operand_b <= '0;
      src_a_q   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      Result    <= '0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        op_q      <= op_in;
        operand_b <= mag_b;
        src_a_q   <= SrcA;
        neg_q     <= a_neg ^ b_neg;
        neg_r     <= a_neg;
        dz_q      <= div_zero_in;
        ovf_q     <= overflow_in;
`ifdef MULDIV_FAST_MUL_EN
        if (is_div_in) acc <= {{DATA_WIDTH{1'b0}}, mag_a};
        else           acc <= {{DATA_WIDTH{1'b0}}, mag_a} * {{DATA_WIDTH{1'b0}}, mag_b};
`else
        acc       <= {{DATA_WIDTH{1'b0}}, mag_a};
`endif
      end else if (state == ST_CALC) begin
        acc <= acc_step;
        cnt <= cnt + 6'd1;
      end
      if (state == ST_FIX && !Flush) Result <= fix_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed and randomized self-checking bench for muldiv_unit.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [2:0]   MulDivOp = 3'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Flush    (Flush),
    .MulDivOp (MulDivOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result)
  );

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
      3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
      3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; pv = p; return pv[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        p = sa % sb; pv = p; return pv[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Clock edges from the accepting edge to the first cycle with Done high.
  function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
                             b == 32'hFFFF_FFFF)))
      return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return W + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request just before an edge and returns 1ns after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] exp_r, input int exp_lat);
    int n;
    n = 0;
    check({tag, " busy"}, 64'(Busy), 64'd1);
    while (Done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, 64'(Result), 64'(exp_r));
    check({tag, " busy_at_done"}, 64'(Busy), 64'd0);
    last_exp = exp_r;
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r);
    @(negedge clk);
    issue(op, a, b);
    wait_done(tag, exp_r, exp_latency(op, a, b));
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           done_seen;

    #1;
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    check("reset result", 64'(Result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    directed("mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("mulh",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    directed("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("divu",      3'd5, 32'd100,        32'd7,         32'd14);
    directed("remu",      3'd7, 32'd100,        32'd7,         32'd2);
    directed("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    directed("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    directed("div_zero",  3'd4, 32'h1234,       32'd0,         32'hFFFF_FFFF);
    directed("rem_zero",  3'd6, 32'h1234,       32'd0,         32'h1234);
    directed("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    directed("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

    // Flush mid-divide: no Done, Result holds the previous value.
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1; Flush = 1'b1;
    @(posedge clk); #1; Flush = 1'b0;
    check("flush busy", 64'(Busy), 64'd0);
    check("flush done", 64'(Done), 64'd0);
    check("flush result", 64'(Result), 64'(last_exp));
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) done_seen++; end
    check("flush no_done", 64'(done_seen), 64'd0);

    // Flush wins over a simultaneous Start.
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; MulDivOp = 3'd5; SrcA = 32'd9; SrcB = 32'd3;
    @(posedge clk); #1; Start = 1'b0; Flush = 1'b0;
    check("flush_start busy", 64'(Busy), 64'd0);

    // Back-to-back: second Start lands in the DONE cycle of the first.
    directed("b2b_first", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678,
             ref_model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678));
    issue(3'd6, 32'hFFFF_FF00, 32'd7);
    wait_done("b2b_second", ref_model(3'd6, 32'hFFFF_FF00, 32'd7),
              exp_latency(3'd6, 32'hFFFF_FF00, 32'd7));

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    issue(3'd0, 32'h1357_9BDF, 32'h0246_8ACE);
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("rst busy", 64'(Busy), 64'd0);
    check("rst done", 64'(Done), 64'd0);
    check("rst result", 64'(Result), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) done_seen++; end
    check("rst no_done", 64'(done_seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      @(negedge clk);
      issue(op, a, b);
      wait_done($sformatf("rand%0d op%0d", i, op), ref_model(op, a, b), exp_latency(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
